// File: rtl/spmmio_arb_pkg.sv
// ---------------------------------------------------------------------------
// spmmio_arb_pkg
// Shared definitions for the two-master spmmio bus arbiter:
//   - arb_state_t      : arbiter FSM states (idle, granted to m0, granted to m1)
//   - M0 / M1          : master index constants, also used as the "last served"
//                        pointer value
//   - DEFAULT_TIMEOUT  : default watchdog limit in cycles
//   - IDLE_DATA        : read data presented to a master that does not own the bus
//   - TIMEOUT_DATA     : read data returned with a watchdog-forced ack
//   - wd_count_width() : watchdog counter width, clamped to 8..16 bits
// ---------------------------------------------------------------------------
package spmmio_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } arb_state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int DEFAULT_TIMEOUT = 255;

    localparam logic [31:0] IDLE_DATA    = 32'h0000_0000;
    localparam logic [31:0] TIMEOUT_DATA = 32'hFFFF_FFFF;

    // Width needed to count up to 'cycles', never narrower than 8 bits and
    // never wider than 16 bits.
    function automatic int wd_count_width(input int cycles);
        int w;
        w = $clog2(cycles + 1);
        if (w < 8)  w = 8;
        if (w > 16) w = 16;
        return w;
    endfunction

endpackage

// File: rtl/spmmio_arb_watchdog.sv
// ---------------------------------------------------------------------------
// spmmio_arb_watchdog
// Counts consecutive un-acknowledged slave strobe cycles of the current bus
// owner. On the TIMEOUT_CYCLES-th stalled strobe cycle it asserts force_ack
// for one cycle so the arbiter can terminate the access, and sets a sticky
// timeout flag that only reset clears.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous reset, active-high
//   s_cyc      in   slave-side cyc (low while idle or while the owner releases)
//   s_stb      in   slave-side strobe
//   s_ack      in   slave acknowledge
//   force_ack  out  one-cycle forced termination of the stalled access
//   timeout    out  sticky watchdog flag
// ---------------------------------------------------------------------------
module spmmio_arb_watchdog
    import spmmio_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic s_cyc,
    input  logic s_stb,
    input  logic s_ack,
    output logic force_ack,
    output logic timeout
);

    localparam int CW = wd_count_width(TIMEOUT_CYCLES);
    // count_reg holds the number of stalled cycles already seen, so the
    // cycle in which it equals LIMIT is the TIMEOUT_CYCLES-th stalled one.
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_reg;
    logic          timeout_reg;
    logic          stalled;

    assign stalled   = s_cyc && s_stb && !s_ack;
    assign force_ack = stalled && (count_reg == LIMIT);
    assign timeout   = timeout_reg;

    // s_cyc is low whenever the arbiter is idle and in the cycle an owner
    // releases the bus, so clearing on !s_cyc also covers every grant change.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg   <= '0;
            timeout_reg <= 1'b0;
        end else begin
            if (!s_cyc || s_ack || force_ack) begin
                count_reg <= '0;
            end else if (s_stb) begin
                count_reg <= count_reg + 1'b1;
            end
            if (force_ack) begin
                timeout_reg <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/spmmio_arbiter.sv
// ---------------------------------------------------------------------------
// spmmio_arbiter
// Two-master / one-slave Wishbone arbiter in front of the spmmio decoder.
// Master 0 is the soft CPU, master 1 a secondary master (debug/DMA). The
// grant is held for the owner's whole cyc, so multi-access sequences are
// atomic; ties from idle are broken round-robin against the last owner.
// The grant is registered (one cycle from request to first slave strobe);
// once granted, the owner's signals pass straight through to the slave and
// the slave ack/data pass straight back, so a combinational-ack slave adds
// no latency.
//
// Optional feature (macro SPMMIO_ARB_TIMEOUT_EN): a watchdog forces a
// one-cycle ack with all-ones read data after TIMEOUT_CYCLES stalled strobe
// cycles and sets the sticky timeout_o flag. Without the macro, timeout_o is
// tied low and a stalled slave stalls the bus.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   m0_* / m1_*                master Wishbone ports (cyc is the request)
//   s_*                        slave-side Wishbone port
//   grant_o                    one-hot owner, bit 0 = m0, bit 1 = m1, 00 idle
//   timeout_o                  sticky watchdog flag
// ---------------------------------------------------------------------------
module spmmio_arbiter
    import spmmio_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [23:0] m0_adr_i,
    input  logic        m0_stb_i,
    input  logic        m0_cyc_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_dat_i,
    output logic        m0_ack_o,
    output logic [31:0] m0_dat_o,

    input  logic [23:0] m1_adr_i,
    input  logic        m1_stb_i,
    input  logic        m1_cyc_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_dat_i,
    output logic        m1_ack_o,
    output logic [31:0] m1_dat_o,

    output logic [23:0] s_adr_o,
    output logic        s_stb_o,
    output logic        s_cyc_o,
    output logic [3:0]  s_sel_o,
    output logic        s_we_o,
    output logic [31:0] s_dat_o,
    input  logic        s_ack_i,
    input  logic [31:0] s_dat_i,

    output logic [1:0]  grant_o,
    output logic        timeout_o
);

    arb_state_t state_reg;
    logic       last_reg;
    logic       force_ack;

    // ------------------------------------------------------------------
    // Arbitration FSM: state and last-served pointer.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            last_reg  <= M1;            // m0 wins the first tie
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (m0_cyc_i && m1_cyc_i) begin
                        if (last_reg == M0) begin
                            state_reg <= ST_GNT1;
                            last_reg  <= M1;
                        end else begin
                            state_reg <= ST_GNT0;
                            last_reg  <= M0;
                        end
                    end else if (m0_cyc_i) begin
                        state_reg <= ST_GNT0;
                        last_reg  <= M0;
                    end else if (m1_cyc_i) begin
                        state_reg <= ST_GNT1;
                        last_reg  <= M1;
                    end
                end
                // The owner keeps the bus while its cyc is high; on release
                // a waiting master is handed the bus without an idle cycle.
                ST_GNT0: begin
                    if (!m0_cyc_i) begin
                        if (m1_cyc_i) begin
                            state_reg <= ST_GNT1;
                            last_reg  <= M1;
                        end else begin
                            state_reg <= ST_IDLE;
                        end
                    end
                end
                ST_GNT1: begin
                    if (!m1_cyc_i) begin
                        if (m0_cyc_i) begin
                            state_reg <= ST_GNT0;
                            last_reg  <= M0;
                        end else begin
                            state_reg <= ST_IDLE;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Slave-side mux and grant decode.
    // ------------------------------------------------------------------
    always_comb begin
        grant_o = 2'b00;
        s_adr_o = '0;
        s_stb_o = 1'b0;
        s_cyc_o = 1'b0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_dat_o = '0;
        unique case (state_reg)
            ST_GNT0: begin
                grant_o = 2'b01;
                s_adr_o = m0_adr_i;
                s_stb_o = m0_stb_i;
                s_cyc_o = m0_cyc_i;
                s_sel_o = m0_sel_i;
                s_we_o  = m0_we_i;
                s_dat_o = m0_dat_i;
            end
            ST_GNT1: begin
                grant_o = 2'b10;
                s_adr_o = m1_adr_i;
                s_stb_o = m1_stb_i;
                s_cyc_o = m1_cyc_i;
                s_sel_o = m1_sel_i;
                s_we_o  = m1_we_i;
                s_dat_o = m1_dat_i;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Master-side responses. Kept separate from the slave mux because
    // force_ack is derived from s_stb_o/s_cyc_o.
    // ------------------------------------------------------------------
    always_comb begin
        m0_ack_o = 1'b0;
        m0_dat_o = IDLE_DATA;
        m1_ack_o = 1'b0;
        m1_dat_o = IDLE_DATA;
        unique case (state_reg)
            ST_GNT0: begin
                m0_ack_o = s_ack_i | force_ack;
                m0_dat_o = force_ack ? TIMEOUT_DATA : s_dat_i;
            end
            ST_GNT1: begin
                m1_ack_o = s_ack_i | force_ack;
                m1_dat_o = force_ack ? TIMEOUT_DATA : s_dat_i;
            end
            default: ;
        endcase
    end

`ifdef SPMMIO_ARB_TIMEOUT_EN
    spmmio_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .s_cyc     (s_cyc_o),
        .s_stb     (s_stb_o),
        .s_ack     (s_ack_i),
        .force_ack (force_ack),
        .timeout   (timeout_o)
    );
`else
    assign force_ack = 1'b0;
    assign timeout_o = 1'b0;
    // Parameter kept in the port list so both builds share one interface.
    logic [31:0] unused_timeout_cfg;
    assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
`endif

endmodule

// File: tb/tb_spmmio_arbiter.sv
// ---------------------------------------------------------------------------
// tb_spmmio_arbiter
// Self-checking bench for spmmio_arbiter: a directed vector table for the
// arbitration rules, hand-written reset/timeout sequences, and a randomized
// phase checked against a behavioural owner/last-served model.
// ---------------------------------------------------------------------------
module tb_spmmio_arbiter;

    localparam int TO_CYCLES = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] m0_adr_i, m1_adr_i;
    logic        m0_stb_i, m1_stb_i, m0_cyc_i, m1_cyc_i;
    logic [3:0]  m0_sel_i, m1_sel_i;
    logic        m0_we_i, m1_we_i;
    logic [31:0] m0_dat_i, m1_dat_i;
    logic        m0_ack_o, m1_ack_o;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic [23:0] s_adr_o;
    logic        s_stb_o, s_cyc_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_dat_o;
    logic        s_ack_i;
    logic [31:0] s_dat_i;
    logic [1:0]  grant_o;
    logic        timeout_o;

    spmmio_arbiter #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
        .clk(clk), .reset(reset),
        .m0_adr_i(m0_adr_i), .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i),
        .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i), .m0_dat_i(m0_dat_i),
        .m0_ack_o(m0_ack_o), .m0_dat_o(m0_dat_o),
        .m1_adr_i(m1_adr_i), .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i),
        .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i), .m1_dat_i(m1_dat_i),
        .m1_ack_o(m1_ack_o), .m1_dat_o(m1_dat_o),
        .s_adr_o(s_adr_o), .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
        .s_sel_o(s_sel_o), .s_we_o(s_we_o), .s_dat_o(s_dat_o),
        .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_sel_i = 4'hF;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_sel_i = 4'hF;
        m0_adr_i = 24'h000004; m1_adr_i = 24'h010000;
        m0_dat_i = 32'h1111_1111; m1_dat_i = 32'h2222_2222;
        s_ack_i = 0; s_dat_i = 32'hDEAD_BEEF;
    endtask

    // Inputs change on the falling edge; outputs are sampled 2 units later.
    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #2;
        check("reset_grant", grant_o, 2'b00);
        check("reset_scyc", {s_cyc_o, s_stb_o}, 2'b00);
        check("reset_acks", {m0_ack_o, m1_ack_o}, 2'b00);
        check("reset_dat", m0_dat_o | m1_dat_o, 32'h0);
        check("reset_timeout", timeout_o, 1'b0);
    endtask

    // Directed vectors: inputs for one cycle and the outputs expected in it.
    typedef struct {
        logic       m0c;
        logic       m1c;
        logic       ack;
        logic [1:0] grant;
        logic       ack0;
        logic       ack1;
    } vec_t;

    vec_t tbl[19];

    // Behavioural model: owner 0 = none, 1 = m0, 2 = m1; last = 0/1.
    int owner, last_srv;

    task automatic model_step(input logic c0, input logic c1);
        int nxt;
        nxt = owner;
        if (owner == 0) begin
            if (c0 && c1)  nxt = (last_srv == 0) ? 2 : 1;
            else if (c0)   nxt = 1;
            else if (c1)   nxt = 2;
        end else if (owner == 1 && !c0) begin
            nxt = c1 ? 2 : 0;
        end else if (owner == 2 && !c1) begin
            nxt = c0 ? 1 : 0;
        end
        if (nxt != 0 && nxt != owner) last_srv = nxt - 1;
        owner = nxt;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: got hang expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [1:0]  eg;
        logic [23:0] ea;
        logic [31:0] ed0, ed1;
        int          ack_at;
        logic [31:0] ack_dat;

        reset = 1'b1;
        idle_inputs();

        //       m0c   m1c   ack   grant   ack0  ack1
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0}; // tie from idle
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0}; // m0 wins first tie
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0}; // m0 releases
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1}; // handover, no bubble
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0}; // second tie
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0}; // alternates to m0
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1}; // m1 locked, m0 waits
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0}; // m1 drops cyc
        tbl[12] = '{1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0}; // m0 finally served
        tbl[13] = '{1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0}; // ack ignored in idle
        tbl[15] = '{1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0}; // lone m0 request
        tbl[16] = '{1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0}; // strobe one cycle later
        tbl[17] = '{1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};

        // ---------------- directed table ----------------
        do_reset();
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            m0_cyc_i = tbl[i].m0c; m0_stb_i = tbl[i].m0c;
            m1_cyc_i = tbl[i].m1c; m1_stb_i = tbl[i].m1c;
            s_ack_i  = tbl[i].ack;
            #2;
            eg  = tbl[i].grant;
            ea  = (eg == 2'b01) ? 24'h000004 : (eg == 2'b10) ? 24'h010000 : 24'h0;
            ed0 = (eg == 2'b01) ? 32'hDEAD_BEEF : 32'h0;
            ed1 = (eg == 2'b10) ? 32'hDEAD_BEEF : 32'h0;
            check($sformatf("vec%0d_grant", i), grant_o, eg);
            check($sformatf("vec%0d_acks", i), {m0_ack_o, m1_ack_o}, {tbl[i].ack0, tbl[i].ack1});
            check($sformatf("vec%0d_adr", i), s_adr_o, ea);
            check($sformatf("vec%0d_dat0", i), m0_dat_o, ed0);
            check($sformatf("vec%0d_dat1", i), m1_dat_o, ed1);
            $display("[TB] vec %0d cyc=%b%b ack=%b grant=%b acks=%b%b", i,
                     tbl[i].m0c, tbl[i].m1c, tbl[i].ack, grant_o, m0_ack_o, m1_ack_o);
        end

        // ---------------- reset during a GNT0 access ----------------
        do_reset();
        @(negedge clk);
        m0_cyc_i = 1; m0_stb_i = 1;
        @(negedge clk);
        #2;
        check("midrst_granted", grant_o, 2'b01);
        reset = 1'b1;
        @(negedge clk);
        s_ack_i = 1'b1;
        #2;
        check("midrst_scyc", s_cyc_o, 1'b0);
        check("midrst_grant", grant_o, 2'b00);
        check("midrst_ack", m0_ack_o, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        #2;
        check("midrst_regrant", grant_o, 2'b01);
        $display("[TB] reset mid-transfer: grant after reset=%b", grant_o);
        idle_inputs();

        // ---------------- randomized vs. model ----------------
        do_reset();
        owner = 0;
        last_srv = 1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if ($urandom_range(3) == 0) m0_cyc_i = ~m0_cyc_i;
            if ($urandom_range(3) == 0) m1_cyc_i = ~m1_cyc_i;
            m0_stb_i = m0_cyc_i & 1'($urandom);
            m1_stb_i = m1_cyc_i & 1'($urandom);
            m0_adr_i = 24'($urandom); m1_adr_i = 24'($urandom);
            m0_sel_i = 4'($urandom);  m1_sel_i = 4'($urandom);
            m0_we_i  = 1'($urandom);  m1_we_i  = 1'($urandom);
            m0_dat_i = $urandom;      m1_dat_i = $urandom;
            s_dat_i  = $urandom;
            s_ack_i  = (cyc % 3 == 0) ? 1'b1 : 1'($urandom);
            #2;
            if (owner == 1) begin
                check("rnd_grant", grant_o, 2'b01);
                check("rnd_bus", {s_cyc_o, s_stb_o, s_we_o, s_sel_o}, {m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i});
                check("rnd_adr", s_adr_o, m0_adr_i);
                check("rnd_wdat", s_dat_o, m0_dat_i);
                check("rnd_acks", {m0_ack_o, m1_ack_o}, {s_ack_i, 1'b0});
                check("rnd_rdat", m0_dat_o ^ m1_dat_o, s_dat_i);
            end else if (owner == 2) begin
                check("rnd_grant", grant_o, 2'b10);
                check("rnd_bus", {s_cyc_o, s_stb_o, s_we_o, s_sel_o}, {m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i});
                check("rnd_adr", s_adr_o, m1_adr_i);
                check("rnd_wdat", s_dat_o, m1_dat_i);
                check("rnd_acks", {m0_ack_o, m1_ack_o}, {1'b0, s_ack_i});
                check("rnd_rdat", m0_dat_o ^ m1_dat_o, s_dat_i);
            end else begin
                check("rnd_grant", grant_o, 2'b00);
                check("rnd_bus", {s_cyc_o, s_stb_o}, 2'b00);
                check("rnd_acks", {m0_ack_o, m1_ack_o}, 2'b00);
                check("rnd_rdat", m0_dat_o | m1_dat_o, 32'h0);
            end
            check("rnd_m0dat_gate", (owner == 1) ? 32'h0 : m0_dat_o, 32'h0);
            if (cyc % 50 == 0)
                $display("[TB] rnd %0d owner=%0d grant=%b", cyc, owner, grant_o);
            model_step(m0_cyc_i, m1_cyc_i);
        end
        idle_inputs();

        // ---------------- stalled slave / watchdog ----------------
        do_reset();
        @(negedge clk);
        m0_cyc_i = 1; m0_stb_i = 1; s_ack_i = 0;
        ack_at = 0;
        ack_dat = 32'h0;
        for (int k = 1; k <= 20 && ack_at == 0; k++) begin
            @(negedge clk);
            #2;
            if (m0_ack_o) begin
                ack_at  = k;
                ack_dat = m0_dat_o;
            end
        end
`ifdef SPMMIO_ARB_TIMEOUT_EN
        check("wd_ack_cycle", ack_at, TO_CYCLES);
        check("wd_ack_dat", ack_dat, 32'hFFFF_FFFF);
        @(negedge clk);
        #2;
        check("wd_flag_set", timeout_o, 1'b1);
        check("wd_no_repeat_ack", m0_ack_o, 1'b0);
        m0_cyc_i = 0; m0_stb_i = 0;
        repeat (3) @(negedge clk);
        #2;
        check("wd_flag_sticky", timeout_o, 1'b1);
`else
        check("stall_no_ack", ack_at, 0);
        check("stall_no_flag", timeout_o, 1'b0);
        check("stall_still_granted", grant_o, 2'b01);
`endif
        $display("[TB] stall test: ack at stall cycle %0d data %h", ack_at, ack_dat);
        do_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spmmio_arbiter.md
Name: spmmio_arbiter

Overview:
- Two-master, one-slave arbiter placed in front of the spmmio decoder.
- Lets the soft CPU (master 0) and a secondary bus master (master 1, e.g. a debug/DMA engine) share the MMIO bus.
- A grant is held for a whole Wishbone cycle (cyc high), so multi-access sequences to sdcard/misc registers are atomic.
- Round-robin fairness between the two masters.

Parameters:
TIMEOUT_CYCLES, 255, cycles of un-acked s_stb_o before the watchdog forces termination (only used with SPMMIO_ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-high
m0_adr_i / m1_adr_i  in  [0:23]  master word address
m0_stb_i / m1_stb_i  in  1  master strobe
m0_cyc_i / m1_cyc_i  in  1  master cycle; this is the bus request
m0_sel_i / m1_sel_i  in  [0:3]  byte selects
m0_we_i / m1_we_i  in  1  write enable
m0_dat_i / m1_dat_i  in  [0:31]  write data
m0_ack_o / m1_ack_o  out  1  acknowledge to master
m0_dat_o / m1_dat_o  out  [0:31]  read data to master
s_adr_o, s_stb_o, s_cyc_o, s_sel_o, s_we_o, s_dat_o  out  [0:23],1,1,[0:3],1,[0:31]  slave-side bus
s_ack_i  in  1  slave acknowledge
s_dat_i  in  [0:31]  slave read data
grant_o  out  [0:1]  one-hot current owner; bit 0 = m0, bit 1 = m1; 2'b00 when idle
timeout_o  out  1  sticky watchdog flag

Behaviour:
- State machine: IDLE, GNT0, GNT1. State and last-served pointer `last` are registered.
- Reset values: state = IDLE, last = 1 (m0 wins the first tie), watchdog count = 0, timeout_o = 0.
- Reset outputs (combinational from state): grant_o = 00, s_cyc_o = 0, s_stb_o = 0, all acks 0, all dat_o = 0.
- IDLE transitions:
  - Only m0_cyc_i high -> GNT0.
  - Only m1_cyc_i high -> GNT1.
  - Both high -> the master not equal to `last`.
  - Neither -> stay in IDLE.
- Arbitration latency: the grant is registered, so the first slave strobe appears one cycle after a master raises cyc from IDLE.
- Entering GNTn sets last = n.
- In GNTn:
  - s_* outputs = master n inputs, combinationally passed through.
  - mn_ack_o = s_ack_i; mn_dat_o = s_dat_i.
  - The other master sees ack = 0, dat = 0 and waits (its stb is ignored, not queued).
- Release: in GNTn, when mn_cyc_i is low:
  - Other master's cyc high -> direct handover to its GNT state next cycle, with no IDLE bubble.
  - Otherwise -> IDLE.
- While mn_cyc_i stays high, the grant is held regardless of the other request. The lock is intentional.
- The slave is combinational-ack: s_ack_i may equal s_stb_o in the same cycle. Single-cycle accesses complete with zero added latency after the grant.
- Ack gating: s_ack_i seen while state = IDLE is ignored; no master is acked.
- Simultaneous events:
  - Granted master drops cyc while the other raises cyc in the same cycle -> handover.
  - Both raise cyc the same cycle from IDLE -> round-robin rule applies.
- Reset mid-transfer: the next edge returns to IDLE; s_cyc_o deasserts that cycle; the in-flight access is abandoned without ack.

Optional Feature:
SPMMIO_ARB_TIMEOUT_EN
- Defined:
  - An 8..16-bit counter (width from TIMEOUT_CYCLES) increments each cycle with s_stb_o = 1 and s_ack_i = 0.
  - The counter clears on ack, on IDLE, and on grant change.
  - When count reaches TIMEOUT_CYCLES, the granted master gets a one-cycle ack with dat_o = 32'hFFFFFFFF, and timeout_o sets.
  - timeout_o stays set until reset. The counter clears after the forced ack.
- Undefined: no counter; timeout_o tied 0; a stalled slave stalls the bus forever.

Decomposition:
- Package spmmio_arb_pkg:
  - State encoding (IDLE, GNT0, GNT1).
  - Master index constants M0 = 0, M1 = 1.
  - DEFAULT_TIMEOUT = 255.
  - Idle read-data constant 32'h00000000 and timeout read-data constant 32'hFFFFFFFF.
- Sub-module spmmio_arb_watchdog holds the timeout counter and sticky flag. It is instantiated only under the macro.

Test Plan:
- After reset, raise m0_cyc_i/stb_i with adr 24'h000004 -> grant_o = 01 one cycle later, s_adr_o = 24'h000004, m0_ack_o pulses, m1_ack_o stays 0.
- Raise m0 and m1 cyc the same cycle after reset -> GNT0 first. m0 drops cyc -> GNT1 on the next cycle with no IDLE. Repeat the tie -> m0 again (alternation).
- m1 holds cyc across 3 stb pulses to 24'h010000 while m0 requests -> m0 never acked until m1 drops cyc, then grant_o = 01.
- Read with s_dat_i = 32'hDEADBEEF while in GNT1 -> m1_dat_o = 32'hDEADBEEF, m0_dat_o = 0.
- Assert reset during a GNT0 access -> s_cyc_o = 0 and grant_o = 00 after the edge, no ack issued.
- With SPMMIO_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 8, hold s_ack_i = 0 -> forced ack at cycle 8 with dat 32'hFFFFFFFF, and timeout_o = 1 until reset.
